// File: rtl/cdb_broadcaster_pkg.sv
// Shared datapath types for the common data bus, plus small helpers used by
// the broadcaster's arbitration and output stage.
package rv32i_types;

  localparam int CDB       = 2;
  localparam int ROB_DEPTH = 8;
  localparam int ROB_ID_W  = $clog2(ROB_DEPTH);

  typedef struct packed {
    logic [ROB_ID_W-1:0] rob_id;
    logic                commit;
  } rob_info_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rd_wdata;
  } rvfi_info_t;

  typedef struct packed {
    rob_info_t  rob;
    logic [4:0] rd_arch;
    logic [5:0] rd_phys;
    rvfi_info_t rvfi;
  } super_dispatch_t;

  typedef struct packed {
    logic            ready_for_writeback;
    super_dispatch_t inst_info;
  } cdb_lane_t;

  typedef cdb_lane_t [CDB-1:0] cdb_t;

endpackage

package cdb_broadcaster_pkg;
  import rv32i_types::*;

  // Listeners treat anything on the bus as completed, so commit is forced.
  function automatic super_dispatch_t mark_commit(super_dispatch_t entry);
    super_dispatch_t tmp;
    tmp            = entry;
    tmp.rob.commit = 1'b1;
    return tmp;
  endfunction

  function automatic int unsigned rr_index(int unsigned base, int unsigned offs,
                                           int unsigned n);
    return (base + offs) % n;
  endfunction

endpackage

// File: rtl/cdb_broadcaster_if.sv
// Result-collection and broadcast signals between the functional units and the
// CDB broadcaster; slave is the broadcaster side, master the producer side.
interface cdb_broadcaster_if
  import rv32i_types::*;
#(
  parameter int NUM_FU = 4
);

  logic [NUM_FU-1:0] fu_valid;
  super_dispatch_t   fu_result [NUM_FU];
  logic [NUM_FU-1:0] fu_ready;
  cdb_t              cdb;

  modport master (
    output fu_valid,
    output fu_result,
    input  fu_ready,
    input  cdb
  );

  modport slave (
    input  fu_valid,
    input  fu_result,
    output fu_ready,
    output cdb
  );

endinterface

// File: rtl/cdb_broadcaster_fu_result_fifo.sv
// Per-unit result buffer: power-of-two circular FIFO with registered count;
// push into a full FIFO and pop from an empty one are ignored.
module fu_result_fifo
  import rv32i_types::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  super_dispatch_t         din,
  input  logic                    pop,
  output logic                    empty,
  output logic                    full,
  output logic [$clog2(DEPTH):0]  count,
  output super_dispatch_t         head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  super_dispatch_t  mem_q [DEPTH];
  super_dispatch_t  mem_d [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  assign empty = (count_q == CNT_W'(0));
  assign full  = (count_q == CNT_W'(DEPTH));
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    push_ok  = push & ~full;
    pop_ok   = pop & ~empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (push_ok) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers; reset discards any buffered results.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/cdb_broadcaster.sv
// Common data bus transmitter: buffers completed results per unit and drives up
// to CDB registered writebacks per cycle, granting units in round-robin order.
module cdb_broadcaster
  import rv32i_types::*;
  import cdb_broadcaster_pkg::*;
#(
  parameter int NUM_FU     = 4,
  parameter int FIFO_DEPTH = 2
) (
  input logic              clk,
  input logic              rst,
  cdb_broadcaster_if.slave bus
);

  localparam int RR_W   = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int LANE_W = (CDB > 1) ? $clog2(CDB) : 1;
  localparam int NG_W   = LANE_W + 1;

  logic [NUM_FU-1:0] fifo_push;
  logic [NUM_FU-1:0] fifo_empty;
  logic [NUM_FU-1:0] fifo_full;
  logic [CNT_W-1:0]  fifo_count [NUM_FU];
  super_dispatch_t   fifo_head  [NUM_FU];
  logic [NUM_FU-1:0] fu_ready_s;

  logic [NUM_FU-1:0] grant;
  logic [CDB-1:0]    lane_vld;
  logic [RR_W-1:0]   lane_src [CDB];
  logic [RR_W-1:0]   last_grant;
  logic [RR_W-1:0]   scan_idx;
  logic [NG_W-1:0]   n_grant;

  logic [RR_W-1:0]   rr_ptr_q, rr_ptr_d;
  cdb_t              cdb_q, cdb_d;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_FU; gi++) begin : g_fu
      assign fifo_push[gi] = bus.fu_valid[gi] & ~fifo_full[gi];

      fu_result_fifo #(
        .DEPTH (FIFO_DEPTH)
      ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push[gi]),
        .din   (bus.fu_result[gi]),
        .pop   (grant[gi]),
        .empty (fifo_empty[gi]),
        .full  (fifo_full[gi]),
        .count (fifo_count[gi]),
        .head  (fifo_head[gi])
      );
    end
  endgenerate

  // Ready is decoded from the registered occupancy only, so a pop this cycle
  // does not reopen a full FIFO until the next one.
  always_comb begin
    fu_ready_s = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      fu_ready_s[i] = (fifo_count[i] < CNT_W'(FIFO_DEPTH));
    end
  end

  // Round-robin scan from rr_ptr; the k-th non-empty unit takes lane k.
  always_comb begin
    grant      = '0;
    lane_vld   = '0;
    n_grant    = '0;
    last_grant = rr_ptr_q;
    scan_idx   = rr_ptr_q;
    for (int j = 0; j < CDB; j++) begin
      lane_src[j] = '0;
    end
    for (int k = 0; k < NUM_FU; k++) begin
      scan_idx = RR_W'(rr_index(32'(rr_ptr_q), 32'(k), 32'(NUM_FU)));
      if (!fifo_empty[scan_idx] && (n_grant < NG_W'(CDB))) begin
        grant[scan_idx]                   = 1'b1;
        lane_vld[n_grant[LANE_W-1:0]]     = 1'b1;
        lane_src[n_grant[LANE_W-1:0]]     = scan_idx;
        n_grant                           = n_grant + NG_W'(1);
        last_grant                        = scan_idx;
      end else begin
        grant[scan_idx] = 1'b0;
      end
    end
  end

  // Lane contents and pointer advance for the next cycle.
  always_comb begin
    cdb_d    = '0;
    rr_ptr_d = rr_ptr_q;
    for (int j = 0; j < CDB; j++) begin
      if (lane_vld[j]) begin
        cdb_d[j].ready_for_writeback = 1'b1;
        cdb_d[j].inst_info           = mark_commit(fifo_head[lane_src[j]]);
      end else begin
        cdb_d[j] = '0;
      end
    end
    if (|grant) begin
      rr_ptr_d = RR_W'(rr_index(32'(last_grant), 32'd1, 32'(NUM_FU)));
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  // Output lanes and arbitration pointer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_q <= '0;
      cdb_q    <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      cdb_q    <= cdb_d;
    end
  end

  assign bus.cdb      = cdb_q;
  assign bus.fu_ready = fu_ready_s;

endmodule

// File: tb/tb_cdb_broadcaster.sv
// Bench for cdb_broadcaster: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_cdb_broadcaster;
  import rv32i_types::*;

  localparam int NF = 4;
  localparam int D  = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cdb_broadcaster_if #(.NUM_FU(NF)) bus ();

  cdb_broadcaster #(
    .NUM_FU     (NF),
    .FIFO_DEPTH (D)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  super_dispatch_t mq [NF][$];
  int              m_rr      = 0;
  cdb_t            exp_cdb   = '0;
  logic [NF-1:0]   exp_ready = '1;
  int              seq [NF];
  logic [NF-1:0]   vin       = '0;
  logic [NF-1:0]   accepted  = '0;
  int              load [NF];

  function automatic super_dispatch_t mk(int u, int s);
    super_dispatch_t e;
    e.rob.rob_id      = 3'((u + 3 + s) % 8);
    e.rob.commit      = s[0];
    e.rd_arch         = 5'(u * 8 + s);
    e.rd_phys         = 6'(s * 5 + u);
    e.rvfi.pc         = {s[23:0], 4'(u), 4'h0};
    e.rvfi.rd_wdata   = 32'hC0DE_0000 ^ 32'(s * 131 + u);
    return e;
  endfunction

  task automatic chk(string name, logic [255:0] act, logic [255:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NF; i++) begin
      bus.fu_valid[i]  = vin[i];
      bus.fu_result[i] = mk(i, seq[i]);
    end
  endtask

  // One clock of the reference: pop up to CDB heads scanning from m_rr, then
  // accept offered results into queues that had room before the edge.
  task automatic model_step();
    logic [NF-1:0]   rdy;
    int              g;
    int              last;
    int              u;
    super_dispatch_t e;
    for (int i = 0; i < NF; i++) rdy[i] = (mq[i].size() < D);
    exp_cdb = '0;
    g       = 0;
    last    = -1;
    for (int k = 0; k < NF; k++) begin
      u = (m_rr + k) % NF;
      if (mq[u].size() != 0 && g < CDB) begin
        e            = mq[u].pop_front();
        e.rob.commit = 1'b1;
        exp_cdb[g]   = {1'b1, e};
        g++;
        last = u;
      end
    end
    if (last >= 0) m_rr = (last + 1) % NF;
    accepted = vin & rdy;
    for (int i = 0; i < NF; i++) begin
      if (accepted[i]) mq[i].push_back(mk(i, seq[i]));
    end
    for (int i = 0; i < NF; i++) exp_ready[i] = (mq[i].size() < D);
  endtask

  task automatic compare_outputs();
    chk("cdb", bus.cdb, exp_cdb);
    chk("fu_ready", bus.fu_ready, exp_ready);
    chk("rr_ptr", dut.rr_ptr_q, 32'(m_rr));
  endtask

  task automatic cycle(input logic [NF-1:0] v);
    @(negedge clk);
    vin = v;
    drive();
    model_step();
    @(posedge clk);
    #1;
    compare_outputs();
    for (int i = 0; i < NF; i++) begin
      if (accepted[i]) seq[i]++;
    end
  endtask

  task automatic reset_checks(string tag);
    chk({tag, "_l0_rwb"}, bus.cdb[0].ready_for_writeback, 1'b0);
    chk({tag, "_l1_rwb"}, bus.cdb[1].ready_for_writeback, 1'b0);
    chk({tag, "_cdb_zero"}, bus.cdb, 256'd0);
    chk({tag, "_fu_ready"}, bus.fu_ready, 4'b1111);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b0;
    vin = '0;
    drive();
    #1;
    reset_checks("rst_mid");
    for (int i = 0; i < NF; i++) mq[i].delete();
    m_rr      = 0;
    exp_cdb   = '0;
    exp_ready = '1;
    accepted  = '0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  int eu0 [4] = '{0, 2, 0, 2};
  int eu1 [4] = '{1, 3, 1, 3};

  initial begin
    logic [NF-1:0] nv;
    for (int i = 0; i < NF; i++) begin
      seq[i]  = 0;
      load[i] = 50;
    end
    vin = '0;
    drive();
    #3;
    reset_checks("por");
    @(negedge clk);
    rst = 1'b1;

    // Single result from unit 2.
    cycle(4'b0100);
    cycle(4'b0000);
    chk("single_l0_rwb", bus.cdb[0].ready_for_writeback, 1'b1);
    chk("single_l0_rob_id", bus.cdb[0].inst_info.rob.rob_id, 3'd5);
    chk("single_l0_commit", bus.cdb[0].inst_info.rob.commit, 1'b1);
    chk("single_l1_idle", bus.cdb[1], 256'd0);

    // Every unit valid with rr_ptr starting at 0.
    do_reset();
    cycle(4'b1111);
    for (int c = 0; c < 4; c++) begin
      cycle(4'b1111);
      chk("allv_l0_rwb", bus.cdb[0].ready_for_writeback, 1'b1);
      chk("allv_l1_rwb", bus.cdb[1].ready_for_writeback, 1'b1);
      chk("allv_l0_unit", bus.cdb[0].inst_info.rvfi.pc[7:4], 32'(eu0[c]));
      chk("allv_l1_unit", bus.cdb[1].inst_info.rvfi.pc[7:4], 32'(eu1[c]));
      if (c == 0) chk("allv_fu_ready", bus.fu_ready, 4'b0011);
    end
    repeat (6) cycle(4'b0000);

    // Unit 0 full while it keeps offering a result.
    do_reset();
    repeat (3) cycle(4'b1111);
    chk("full_ready0_low", bus.fu_ready[0], 1'b0);
    cycle(4'b0001);
    chk("full_ready0_back", bus.fu_ready[0], 1'b1);
    cycle(4'b0001);
    repeat (6) cycle(4'b0000);

    // Wrap: rr_ptr at 3 with units 3 and 0 pending.
    do_reset();
    cycle(4'b0100);
    cycle(4'b1001);
    cycle(4'b0000);
    chk("wrap_l0_unit", bus.cdb[0].inst_info.rvfi.pc[7:4], 4'd3);
    chk("wrap_l1_unit", bus.cdb[1].inst_info.rvfi.pc[7:4], 4'd0);
    chk("wrap_rr", dut.rr_ptr_q, 2'd1);

    // Idle stretch.
    repeat (10) begin
      cycle(4'b0000);
      chk("idle_cdb", bus.cdb, 256'd0);
      chk("idle_ready", bus.fu_ready, 4'b1111);
      chk("idle_rr", dut.rr_ptr_q, 2'd1);
    end

    // Reset with results buffered; nothing stale may appear afterwards.
    do_reset();
    repeat (3) cycle(4'b1111);
    do_reset();
    repeat (4) begin
      cycle(4'b0000);
      chk("post_rst_idle", bus.cdb, 256'd0);
    end

    // Randomized traffic with per-phase load and occasional resets.
    for (int n = 0; n < 3000; n++) begin
      if (n % 500 == 0) begin
        for (int i = 0; i < NF; i++) load[i] = int'($urandom_range(5, 95));
      end
      if ($urandom_range(0, 599) == 0) do_reset();
      for (int i = 0; i < NF; i++) begin
        if (vin[i] && !accepted[i]) nv[i] = ($urandom_range(0, 9) != 0);
        else                        nv[i] = (int'($urandom_range(0, 99)) < load[i]);
      end
      cycle(nv);
    end
    repeat (6) cycle(4'b0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

endmodule
